// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, loader FSM state encoding and ALU opcode constants.
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W = 6;
  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_WAIT_OP = 2'd2,
    S_DONE    = 2'd3
  } state_t;
  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SLT = 6'b101010;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: optional 2-flop synchroniser (ALU_LOADER_SYNC2_EN), counter debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic mclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  logic w_in;
  logic r_level;
  logic r_level_d;
  logic [7:0] r_cnt;
`ifdef ALU_LOADER_SYNC2_EN
  logic [1:0] r_sync;
  always_ff @(posedge mclk or posedge reset)
    if (reset) r_sync <= '0;
    else r_sync <= {r_sync[0], raw};
  assign w_in = r_sync[1];
`else
  assign w_in = raw;
`endif
  // a new level must persist DEBOUNCE_CYCLES consecutive edges; any return to the old level restarts the count
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_level <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_level_d <= r_level;
      if (w_in == r_level) r_cnt <= '0;
      else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 8'd1;
    end
  end
  assign level = r_level;
  assign press = r_level & ~r_level_d;
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced buttons load operands A/B and opcode into ALU-facing registers.
// Build option: ALU_LOADER_SYNC2_EN adds a 2-flop synchroniser per button.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W = alu_pkg::OP_W,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switch,
  input  logic              b1,
  input  logic              b2,
  input  logic              b3,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   op,
  output logic              op_valid,
  output logic [1:0]        state
);
  logic [2:0] w_level;
  logic [2:0] w_press;
  logic [2:0] w_p;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0] r_op;
  logic r_op_valid;
  state_t r_state;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (.mclk(mclk), .reset(reset), .raw(b1), .level(w_level[0]), .press(w_press[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (.mclk(mclk), .reset(reset), .raw(b2), .level(w_level[1]), .press(w_press[1]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (.mclk(mclk), .reset(reset), .raw(b3), .level(w_level[2]), .press(w_press[2]));
  assign w_p = w_press & w_level;
  // b1 restarts from any state; a b2 pulse swallows a coincident b3 even when b2 itself is ignored
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_op_valid <= 1'b0;
      r_state <= S_WAIT_A;
    end else begin
      r_op_valid <= 1'b0;
      if (w_p[0]) begin
        r_a <= switch;
        r_state <= S_WAIT_B;
      end else if (w_p[1]) begin
        if (r_state == S_WAIT_B) begin
          r_b <= switch;
          r_state <= S_WAIT_OP;
        end
      end else if (w_p[2] && (r_state == S_WAIT_OP || r_state == S_DONE)) begin
        r_op <= switch[OP_W-1:0];
        r_op_valid <= 1'b1;
        r_state <= S_DONE;
      end
    end
  end
  assign a = r_a;
  assign b = r_b;
  assign op = r_op;
  assign op_valid = r_op_valid;
  assign state = r_state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: table-driven load/order/priority vectors plus bounce, hold, reset and latency sequences.
module tb_alu_operand_loader;
  logic mclk = 1'b0;
  logic reset;
  logic [7:0] switch;
  logic b1, b2, b3;
  logic [7:0] a, b;
  logic [5:0] op;
  logic op_valid;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
`ifdef ALU_LOADER_SYNC2_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif
  typedef struct {
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [1:0] st;
    int ov;
  } vec_t;
  vec_t v[14];
  always #5 mclk = ~mclk;
  alu_operand_loader #(.DATA_W(8), .OP_W(6), .DEBOUNCE_CYCLES(4)) dut (
    .mclk(mclk), .reset(reset), .switch(switch), .b1(b1), .b2(b2), .b3(b3),
    .a(a), .b(b), .op(op), .op_valid(op_valid), .state(state)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge mclk);
    #1;
    if (op_valid) ov_cnt++;
  endtask
  task automatic check_all(input string n, input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] eop, input logic [1:0] est);
    chk({n, " a"}, 32'(a), 32'(ea));
    chk({n, " b"}, 32'(b), 32'(eb));
    chk({n, " op"}, 32'(op), 32'(eop));
    chk({n, " state"}, 32'(state), 32'(est));
  endtask
  initial begin
    int k;
    v[0]  = '{8'h01, 3'b100, 8'h00, 8'h00, 6'h00, 2'd0, 0};
    v[1]  = '{8'h01, 3'b010, 8'h00, 8'h00, 6'h00, 2'd0, 0};
    v[2]  = '{8'h7F, 3'b001, 8'h7F, 8'h00, 6'h00, 2'd1, 0};
    v[3]  = '{8'h01, 3'b001, 8'h01, 8'h00, 6'h00, 2'd1, 0};
    v[4]  = '{8'h01, 3'b010, 8'h01, 8'h01, 6'h00, 2'd2, 0};
    v[5]  = '{8'h20, 3'b100, 8'h01, 8'h01, 6'h20, 2'd3, 1};
    v[6]  = '{8'h22, 3'b100, 8'h01, 8'h01, 6'h22, 2'd3, 1};
    v[7]  = '{8'h33, 3'b010, 8'h01, 8'h01, 6'h22, 2'd3, 0};
    v[8]  = '{8'h05, 3'b001, 8'h05, 8'h01, 6'h22, 2'd1, 0};
    v[9]  = '{8'h06, 3'b010, 8'h05, 8'h06, 6'h22, 2'd2, 0};
    v[10] = '{8'h05, 3'b101, 8'h05, 8'h06, 6'h22, 2'd1, 0};
    v[11] = '{8'h10, 3'b110, 8'h05, 8'h10, 6'h22, 2'd2, 0};
    v[12] = '{8'hC7, 3'b100, 8'h05, 8'h10, 6'h07, 2'd3, 1};
    v[13] = '{8'hC9, 3'b100, 8'h05, 8'h10, 6'h09, 2'd3, 1};
    reset = 1'b1;
    switch = 8'h00;
    {b3, b2, b1} = 3'b000;
    #12;
    check_all("reset", 8'h00, 8'h00, 6'h00, 2'd0);
    chk("reset op_valid", 32'(op_valid), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      switch = v[i].sw;
      ov_cnt = 0;
      {b3, b2, b1} = v[i].btn;
      repeat (6) step();
      {b3, b2, b1} = 3'b000;
      repeat (6) step();
      check_all($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].op, v[i].st);
      chk($sformatf("vec%0d op_valid cycles", i), 32'(ov_cnt), 32'(v[i].ov));
    end
    // bounce on b1 never reaches the debounced level
    switch = 8'hAA;
    ov_cnt = 0;
    b1 = 1'b1; step(); b1 = 1'b0; step(); b1 = 1'b1; step(); b1 = 1'b0; step();
    repeat (8) step();
    check_all("bounce", 8'h05, 8'h10, 6'h09, 2'd3);
    chk("bounce op_valid", 32'(ov_cnt), 32'd0);
    // long hold gives one pulse
    switch = 8'h22;
    ov_cnt = 0;
    b3 = 1'b1;
    repeat (50) step();
    b3 = 1'b0;
    repeat (6) step();
    chk("hold50 op", 32'(op), 32'h22);
    chk("hold50 pulses", 32'(ov_cnt), 32'd1);
    // release bounce must not re-trigger
    switch = 8'h2A;
    ov_cnt = 0;
    b3 = 1'b1;
    repeat (6) step();
    b3 = 1'b0; step(); step(); b3 = 1'b1; step(); b3 = 1'b0; step(); step(); b3 = 1'b1; step();
    b3 = 1'b0;
    repeat (8) step();
    chk("release bounce op", 32'(op), 32'h2A);
    chk("release bounce pulses", 32'(ov_cnt), 32'd1);
    // async reset in S_DONE, no clock edge before the check
    #2;
    reset = 1'b1;
    #1;
    check_all("async reset", 8'h00, 8'h00, 6'h00, 2'd0);
    chk("async reset op_valid", 32'(op_valid), 32'd0);
    step();
    reset = 1'b0;
    // reset mid-debounce, button still held: re-debounce and measure latency
    switch = 8'h3C;
    b1 = 1'b1;
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset state", 32'(state), 32'd0);
    step();
    reset = 1'b0;
    k = 0;
    while (a !== 8'h3C && k < 20) begin
      step();
      k++;
    end
    chk("latency edges", 32'(k), 32'(LAT));
    switch = 8'h3D;
    repeat (20) step();
    b1 = 1'b0;
    repeat (8) step();
    chk("held after reset a", 32'(a), 32'h3C);
    chk("held after reset state", 32'(state), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
